// File: rtl/vec_dot_product_stream_if.sv
// Stream bundle for vec_dot_product_stream: beat input channel and result output channel.
// The master drives beats and consumes results; the slave is the dot-product engine.
interface vec_dot_product_stream_if #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int LANES         = 8,
    parameter int MAX_BEATS     = 4
);
    localparam int ACC_WIDTH  = 2*ELEMENT_WIDTH + $clog2(LANES*MAX_BEATS);
    localparam int BEAT_WIDTH = $clog2(MAX_BEATS+1);

    logic                           in_valid;
    logic                           in_ready;
    logic [LANES*ELEMENT_WIDTH-1:0] in_a;
    logic [LANES*ELEMENT_WIDTH-1:0] in_b;
    logic [LANES-1:0]               in_keep;
    logic                           in_last;
    logic                           in_signed;

    logic                           out_valid;
    logic                           out_ready;
    logic [ACC_WIDTH-1:0]           out_dot;
    logic [BEAT_WIDTH-1:0]          out_beats;
    logic                           out_trunc;

    modport master (
        output in_valid, in_a, in_b, in_keep, in_last, in_signed, out_ready,
        input  in_ready, out_valid, out_dot, out_beats, out_trunc
    );

    modport slave (
        input  in_valid, in_a, in_b, in_keep, in_last, in_signed, out_ready,
        output in_ready, out_valid, out_dot, out_beats, out_trunc
    );
endinterface

// File: rtl/vec_dot_product_stream.sv
// Streaming dot-product engine: LANES-wide beats -> registered products -> balanced adder tree
// -> accumulator, one registered result per vector with signed/unsigned mode fixed at the first beat.
module vec_dot_product_stream #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int LANES         = 8,
    parameter int MAX_BEATS     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vec_dot_product_stream_if.slave bus
);
    localparam int ACC_WIDTH  = 2*ELEMENT_WIDTH + $clog2(LANES*MAX_BEATS);
    localparam int BEAT_WIDTH = $clog2(MAX_BEATS+1);
    localparam int PROD_WIDTH = 2*ELEMENT_WIDTH;
    localparam int TREE_DEPTH = $clog2(LANES);
    localparam logic [BEAT_WIDTH-1:0] LAST_CNT = BEAT_WIDTH'(MAX_BEATS-1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t state_q, state_d;

    logic                  can_accept;
    logic                  accept;
    logic                  eff_signed;
    logic                  eff_last;
    logic                  trunc_d;
    logic                  mode_q;
    logic [BEAT_WIDTH-1:0] beat_cnt_q;

    logic [PROD_WIDTH-1:0] prod_d  [LANES];
    logic [PROD_WIDTH-1:0] s1_prod [LANES];
    logic                  s1_valid;
    logic                  s1_signed;
    logic                  s1_last;
    logic                  s1_trunc;
    logic [BEAT_WIDTH-1:0] s1_beats;

    logic [ACC_WIDTH-1:0]  ext [LANES];
    logic [ACC_WIDTH-1:0]  tree_sum;
    logic [ACC_WIDTH-1:0]  acc_q;

    assign can_accept    = (state_q == IDLE) || (state_q == ACCUM);
    assign accept        = bus.in_valid && can_accept;
    assign bus.in_ready  = can_accept;
    assign bus.out_valid = (state_q == HOLD);

    // The mode of a vector is whatever in_signed says on its first beat.
    assign eff_signed = (state_q == IDLE) ? bus.in_signed : mode_q;
    assign trunc_d    = !bus.in_last && (beat_cnt_q == LAST_CNT);
    assign eff_last   = bus.in_last || trunc_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ELEMENT_WIDTH-1:0] a;
        logic [ELEMENT_WIDTH-1:0] b;
        logic [PROD_WIDTH-1:0]    sprod;
        logic [PROD_WIDTH-1:0]    uprod;

        assign a     = bus.in_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        assign b     = bus.in_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        assign sprod = PROD_WIDTH'($signed(a)) * PROD_WIDTH'($signed(b));
        assign uprod = PROD_WIDTH'(a) * PROD_WIDTH'(b);
        assign prod_d[i] = !bus.in_keep[i] ? '0 : (eff_signed ? sprod : uprod);

        assign ext[i] = s1_signed ? ACC_WIDTH'($signed(s1_prod[i]))
                                  : ACC_WIDTH'(s1_prod[i]);
    end

    // One array per tree level keeps every node a pure function of the level below.
    for (genvar l = 0; l <= TREE_DEPTH; l++) begin : g_lvl
        localparam int NODES = LANES >> l;
        logic [ACC_WIDTH-1:0] node [NODES];
        for (genvar n = 0; n < NODES; n++) begin : g_node
            if (l == 0) begin : g_leaf
                assign node[n] = ext[n];
            end else begin : g_add
                assign node[n] = g_lvl[l-1].node[2*n] + g_lvl[l-1].node[2*n+1];
            end
        end
    end
    assign tree_sum = g_lvl[TREE_DEPTH].node[0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d takes a default before the case so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (accept) state_d = eff_last ? DRAIN : ACCUM;
            DRAIN:       state_d = HOLD;
            HOLD:        if (bus.out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 1'b0;
            beat_cnt_q <= '0;
            s1_valid   <= 1'b0;
            s1_signed  <= 1'b0;
            s1_last    <= 1'b0;
            s1_trunc   <= 1'b0;
            s1_beats   <= '0;
            // NOTE: the product array is a small register bank, not RAM, so it is cleared by reset.
            for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
            acc_q         <= '0;
            bus.out_dot   <= '0;
            bus.out_beats <= '0;
            bus.out_trunc <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod    <= prod_d;
                s1_signed  <= eff_signed;
                s1_last    <= eff_last;
                s1_trunc   <= trunc_d;
                s1_beats   <= beat_cnt_q + 1'b1;
                mode_q     <= eff_signed;
                beat_cnt_q <= eff_last ? '0 : beat_cnt_q + 1'b1;
            end

            if (s1_valid) begin
                if (s1_last) begin
                    bus.out_dot   <= acc_q + tree_sum;
                    bus.out_beats <= s1_beats;
                    bus.out_trunc <= s1_trunc;
                    acc_q         <= '0;
                end else begin
                    acc_q <= acc_q + tree_sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_dot_product_stream.sv
// Directed bench for vec_dot_product_stream: single-beat vector table plus hand-written
// multi-beat, truncation, back-pressure and mid-vector reset sequences.
module tb_vec_dot_product_stream;
    localparam int EW  = 8;
    localparam int L   = 8;
    localparam int MB  = 4;
    localparam int ACC = 2*EW + $clog2(L*MB);

    typedef struct {
        string          name;
        logic [L*EW-1:0] a;
        logic [L*EW-1:0] b;
        logic [L-1:0]    keep;
        logic            sgn;
        longint          dot;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    vec_dot_product_stream_if #(.ELEMENT_WIDTH(EW), .LANES(L), .MAX_BEATS(MB)) bus ();

    vec_dot_product_stream #(.ELEMENT_WIDTH(EW), .LANES(L), .MAX_BEATS(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [L*EW-1:0] rep(input int v);
        logic [EW-1:0] e;
        e = EW'(v);
        return {L{e}};
    endfunction

    function automatic logic [63:0] dot64(input longint v);
        logic [ACC-1:0] t;
        t = ACC'(v);
        return 64'(t);
    endfunction

    // Drive a beat at a negedge, wait (bounded) for in_ready, and return at the negedge after acceptance.
    task automatic send_beat(input logic [L*EW-1:0] a, input logic [L*EW-1:0] b,
                             input logic [L-1:0] keep, input logic last, input logic sgn);
        int guard = 0;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_keep   = keep;
        bus.in_last   = last;
        bus.in_signed = sgn;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge after the accepting edge of the final beat.
    task automatic expect_result(input string name, input longint dot, input int beats,
                                 input logic trunc, input int hold);
        check({name, "_early_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_drain_ready"}, 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_dot"},   64'(bus.out_dot), dot64(dot));
        check({name, "_beats"}, 64'(bus.out_beats), 64'(beats));
        check({name, "_trunc"}, 64'(bus.out_trunc), 64'(trunc));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({name, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
            check({name, "_hold_dot"},   64'(bus.out_dot), dot64(dot));
            check({name, "_hold_beats"}, 64'(bus.out_beats), 64'(beats));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_post_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        vec_t          tbl[6];
        logic [L*EW-1:0] ramp;

        for (int i = 0; i < L; i++) ramp[i*EW +: EW] = EW'(i + 1);

        tbl[0] = '{"u_max",      rep(255),  rep(255), 8'hFF, 1'b0, 64'sd520200};
        tbl[1] = '{"u_keep1",    ramp,      rep(2),   8'h01, 1'b0, 64'sd2};
        tbl[2] = '{"s_neg",      rep(-1),   rep(5),   8'hFF, 1'b1, -64'sd40};
        tbl[3] = '{"s_keep0",    rep(-7),   rep(9),   8'h00, 1'b1, 64'sd0};
        tbl[4] = '{"u_odd",      rep(128),  rep(255), 8'hAA, 1'b0, 64'sd130560};
        tbl[5] = '{"s_odd",      rep(-128), rep(-1),  8'hAA, 1'b1, 64'sd512};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_keep   = '0;
        bus.in_last   = 1'b0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_dot",   64'(bus.out_dot), 64'd0);
        check("rst_out_beats", 64'(bus.out_beats), 64'd0);
        check("rst_out_trunc", 64'(bus.out_trunc), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            send_beat(tbl[v].a, tbl[v].b, tbl[v].keep, 1'b1, tbl[v].sgn);
            expect_result(tbl[v].name, tbl[v].dot, 1, 1'b0, 0);
        end

        // Signed two-beat vector; in_signed dropped on the second beat must be ignored.
        send_beat(rep(-128), rep(-128), 8'hFF, 1'b0, 1'b1);
        send_beat(rep(-128), rep(127),  8'hFF, 1'b1, 1'b0);
        expect_result("s_two_beat", 64'sd1024, 2, 1'b0, 0);

        // Four beats with no last: forced termination, then a fresh vector.
        for (int k = 0; k < MB; k++) send_beat(rep(1), rep(1), 8'hFF, 1'b0, 1'b0);
        expect_result("trunc", 64'sd32, 4, 1'b1, 0);
        send_beat(rep(2), rep(2), 8'hFF, 1'b1, 1'b0);
        expect_result("after_trunc", 64'sd32, 1, 1'b0, 0);

        // Back-pressure: result held 5 cycles while the next beat waits upstream.
        send_beat(rep(4), rep(5), 8'h0F, 1'b1, 1'b0);
        bus.in_a      = rep(6);
        bus.in_b      = rep(7);
        bus.in_keep   = 8'hFF;
        bus.in_last   = 1'b1;
        bus.in_signed = 1'b0;
        bus.in_valid  = 1'b1;
        expect_result("hold", 64'sd80, 1, 1'b0, 5);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_result("after_hold", 64'sd336, 1, 1'b0, 0);

        // Reset in the middle of a three-beat vector.
        send_beat(rep(1), rep(2), 8'hFF, 1'b0, 1'b0);
        send_beat(rep(1), rep(2), 8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_dot",   64'(bus.out_dot), 64'd0);
        check("mid_rst_out_beats", 64'(bus.out_beats), 64'd0);
        check("mid_rst_out_trunc", 64'(bus.out_trunc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(rep(3), rep(3), 8'hFF, 1'b1, 1'b0);
        expect_result("post_rst", 64'sd72, 1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_dot_product_stream.md
# vec_dot_product_stream

Streaming, parametrised dot-product engine with runtime signed/unsigned mode. Accepts vectors of arbitrary length as a sequence of LANES-wide beats over a valid/ready handshake and multiplies the lanes in parallel. A registered product stage and a balanced adder tree feed an accumulator. Returns one registered result per vector over a second valid/ready handshake. Successor to the fixed 8x8 combinational dot-product blocks; sits between operand buffers and the result FIFO in the compute datapath.

## Interface
- ELEMENT_WIDTH, 8, bits per element
- LANES, 8, elements per beat; power of two, ≥2
- MAX_BEATS, 4, max beats per vector; ≥1
- ACC_WIDTH, derived = 2*ELEMENT_WIDTH + $clog2(LANES*MAX_BEATS), not overridable
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_a, in_b  in  LANES*ELEMENT_WIDTH  lane i at [i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
- in_keep  in  LANES  lane i contributes only when in_keep[i]=1
- in_last  in  1  final beat of vector
- in_signed  in  1  two's-complement mode; sampled on first beat of a vector
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_dot  out  ACC_WIDTH  result; two's complement if signed mode, else unsigned
- out_beats  out  $clog2(MAX_BEATS+1)  beats accumulated
- out_trunc  out  1  vector force-terminated at MAX_BEATS

## Operation
- Reset: in_ready=1, out_valid=0, out_dot=0, out_beats=0, out_trunc=0; accumulator, beat counter, stage-1 registers cleared. Reset mid-vector or mid-output discards all state; no partial result emitted.
- States: IDLE (no beats of current vector yet), ACCUM (≥1 beat accepted, last not yet seen), DRAIN (last beat in stage 1), HOLD (out_valid=1).
- IDLE→ACCUM on accepted non-last beat; IDLE/ACCUM→DRAIN on accepted last beat; DRAIN→HOLD next cycle; HOLD→IDLE on output handshake.
- Mode latched at the first accepted beat; in_signed on later beats ignored.
- Stage 1 (per accepted beat): product[i] = a_i*b_i, signed or unsigned per latched mode, forced to 0 when in_keep[i]=0; 2*ELEMENT_WIDTH bits each.
- Stage 2: balanced adder tree over LANES products, sign- or zero-extended to ACC_WIDTH, added into accumulator. No overflow is possible at ACC_WIDTH; no saturation logic.
- Beat counter increments per accepted beat. The MAX_BEATS-th beat with in_last=0 is treated as last and sets out_trunc=1. The next beat then starts a new vector.
- On the last beat reaching stage 2: out_dot ← accumulator + tree sum, out_beats ← count, accumulator and counter cleared.
- An all-zero in_keep beat is legal; it counts as a beat and contributes 0.

## Timing
- in_ready = (state is IDLE or ACCUM); combinational from registers only, no input→output combinational path.
- Within a vector, one beat per cycle at full throughput.
- Last beat accepted at edge k → out_valid=1 after edge k+1 (2-cycle latency).
- out_dot, out_beats and out_trunc are stable while out_valid=1 and out_ready=0.
- Handshake at edge h → out_valid=0 and in_ready=1 after edge h. With out_ready tied high, the minimum gap between vectors is 3 cycles (last-beat edge to next accepted beat).
- Beats presented while in_ready=0 are not consumed; the upstream source must hold them.

## Test plan
- Unsigned, 1 beat, all lanes a=255, b=255, keep=FF, last=1 → out_dot=520200, out_beats=1, out_trunc=0, out_valid 2 cycles after accept.
- Signed, 2 beats: beat0 a=-128,b=-128 all lanes; beat1 a=-128,b=127 all lanes, last on beat1 → out_dot=131072−130048=1024; in_signed toggled on beat1 has no effect.
- in_keep=0x01 with a_i=i+1, b_i=2 on every lane, 1 beat → out_dot=2.
- 4 beats without last (MAX_BEATS=4), each beat a=b=1 all lanes → out_dot=32, out_beats=4, out_trunc=1; a 5th beat begins a new vector.
- out_ready low for 5 cycles after out_valid → outputs held, in_ready=0 throughout; handshake → next vector accepted on the following cycle with no data loss.
- rst_n asserted after 2 of 3 beats → all outputs at reset values immediately; a post-reset single beat a=b=3 all lanes → out_dot=72.
